// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS instruction-fetch stage.
package mips_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam int unsigned PC_INC     = 4;
  localparam int unsigned ALIGN_MASK = 3;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous clear wins, then enable; an enabled
// cycle without a load inserts a bubble but keeps the last word visible.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              load,
  input  logic [INST_W-1:0] inst_in,
  input  logic [PC_W-1:0]   pc4_in,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   pc4,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (clr) begin
      inst  <= INST_W'(NOP_INST);
      pc4   <= '0;
      valid <= 1'b0;
    end else if (en) begin
      valid <= load;
      if (load) begin
        inst <= inst_in;
        pc4  <= pc4_in;
      end
    end
  end

endmodule

// File: rtl/fetch_if_id_stage.sv
// Instruction fetch: owns the PC, drives the imem req/ready handshake and
// feeds the IF/ID register; handles decode stalls and D/E redirects.
module fetch_if_id_stage
  import mips_pkg::*;
#(
  parameter int unsigned    PC_W     = 32,
  parameter int unsigned    INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stallD,
  input  logic              PCSelectD,
  input  logic [PC_W-1:0]   pcBranchD,
  input  logic              PCSelectE,
  input  logic [PC_W-1:0]   pcTargetE,
  output logic [INST_W-1:0] instcode,
  output logic [PC_W-1:0]   pcPlus4D,
  output logic              validD
);

  fetch_state_t      state;
  logic [PC_W-1:0]   pc_f;
  logic [PC_W-1:0]   pend_pc;
  logic [PC_W-1:0]   pc_seq;
  logic [PC_W-1:0]   target;
  logic [INST_W-1:0] hold_word;
  logic [INST_W-1:0] load_word;
  logic              req;
  logic              redirect;
  logic              load;

  // Redirect arbitration (execute beats decode; decode waits out a stall) and IF/ID load select.
  always_comb begin
    redirect  = PCSelectE | (PCSelectD & ~stallD);
    target    = (PCSelectE ? pcTargetE : pcBranchD) & ~PC_W'(ALIGN_MASK);
    pc_seq    = pc_f + PC_W'(PC_INC);
    load      = 1'b0;
    load_word = imem_rdata;
    case (state)
      S_FETCH: load = imem_ready & ~stallD;
      S_HOLD: begin
        load      = ~stallD;
        load_word = hold_word;
      end
      default: load = 1'b0;
    endcase
  end

  // Fetch FSM; a request already on the bus is never withdrawn, so a redirect
  // without ready parks the target in pend_pc until the wrong-path word returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_START;
      pc_f      <= RESET_PC;
      pend_pc   <= '0;
      hold_word <= INST_W'(NOP_INST);
      req       <= 1'b0;
    end else begin
      case (state)
        S_START: begin
          state <= S_FETCH;
          req   <= 1'b1;
          if (redirect) pc_f <= target;
        end
        S_FETCH: begin
          if (redirect) begin
            if (imem_ready) begin
              pc_f <= target;
            end else begin
              pend_pc <= target;
              state   <= S_DRAIN;
            end
          end else if (imem_ready) begin
            if (stallD) begin
              hold_word <= imem_rdata;
              state     <= S_HOLD;
              req       <= 1'b0;
            end else begin
              pc_f <= pc_seq;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_f  <= target;
            state <= S_FETCH;
            req   <= 1'b1;
          end else if (!stallD) begin
            pc_f  <= pc_seq;
            state <= S_FETCH;
            req   <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (imem_ready) begin
            pc_f  <= redirect ? target : pend_pc;
            state <= S_FETCH;
          end else if (redirect) begin
            pend_pc <= target;
          end
        end
        default: begin
          state <= S_START;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req;
  assign imem_addr = pc_f;

  if_id_reg #(
    .PC_W  (PC_W),
    .INST_W(INST_W)
  ) u_if_id (
    .clk    (clk),
    .clr    (rst | redirect),
    .en     (~stallD),
    .load   (load),
    .inst_in(load_word),
    .pc4_in (pc_seq),
    .inst   (instcode),
    .pc4    (pcPlus4D),
    .valid  (validD)
  );

endmodule
